// File: rtl/gpio_bank.sv
// Parametrised GPIO bank for the j1 IO bus: per-pin direction, atomic set/clear/toggle,
// synchronised inputs, rising/falling edge detection with sticky pending flags and a level irq.
module gpio_bank #(
    parameter int              WIDTH       = 8,
    parameter int              SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] OUT_RESET  = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sel,
    input  logic             io_wr,
    input  logic             io_rd,
    input  logic [3:0]       io_addr,
    input  logic [15:0]      io_wdata,
    output logic [15:0]      io_rdata,
    input  logic [WIDTH-1:0] pin_in,
    output logic [WIDTH-1:0] pin_out,
    output logic [WIDTH-1:0] pin_oe,
    output logic             irq
);

    localparam logic [3:0] A_OUT  = 4'd0;
    localparam logic [3:0] A_DIR  = 4'd1;
    localparam logic [3:0] A_IN   = 4'd2;
    localparam logic [3:0] A_SET  = 4'd3;
    localparam logic [3:0] A_CLR  = 4'd4;
    localparam logic [3:0] A_TGL  = 4'd5;
    localparam logic [3:0] A_RISE = 4'd6;
    localparam logic [3:0] A_FALL = 4'd7;
    localparam logic [3:0] A_PEND = 4'd8;

    // Bus handshake: io_wr/io_rd are single-cycle strobes that count only while sel is high;
    // there is no ready/wait, every qualified access completes on the next posedge.
    logic wr_en;
    logic rd_en;
    assign wr_en = sel & io_wr;
    assign rd_en = sel & io_rd;

    logic [WIDTH-1:0] wd;
    assign wd = io_wdata[WIDTH-1:0];

    generate
        if (WIDTH < 16) begin : g_unused_hi
            logic unused_wdata_hi;
            assign unused_wdata_hi = ^io_wdata[15:WIDTH];
        end
    endgenerate

    logic [WIDTH-1:0] out_q,  out_d;
    logic [WIDTH-1:0] dir_q,  dir_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [WIDTH-1:0] prev_q;
    logic [15:0]      rdata_q, rdata_d;
    logic             irq_q;

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] in_w;
    assign in_w = sync_q[SYNC_STAGES-1];

    logic [WIDTH-1:0] rise_ev;
    logic [WIDTH-1:0] fall_ev;
    logic [WIDTH-1:0] w1c;
    assign rise_ev = in_w & ~prev_q & rise_q;
    assign fall_ev = ~in_w & prev_q & fall_q;
    assign w1c     = (wr_en && io_addr == A_PEND) ? wd : '0;

    function automatic logic [15:0] zext(input logic [WIDTH-1:0] v);
        zext = '0;
        zext[WIDTH-1:0] = v;
    endfunction

    always_comb begin
        out_d  = out_q;
        dir_d  = dir_q;
        rise_d = rise_q;
        fall_d = fall_q;
        if (wr_en) begin
            case (io_addr)
                A_OUT:   out_d  = wd;
                A_DIR:   dir_d  = wd;
                A_SET:   out_d  = out_q | wd;
                A_CLR:   out_d  = out_q & ~wd;
                A_TGL:   out_d  = out_q ^ wd;
                A_RISE:  rise_d = wd;
                A_FALL:  fall_d = wd;
                default: ;
            endcase
        end
    end

    // A fresh edge in the same cycle as its clear keeps the bit set.
    assign pend_d = (pend_q & ~w1c) | rise_ev | fall_ev;

    // Reads capture pre-write register values, so a same-cycle write is not visible.
    always_comb begin
        rdata_d = rdata_q;
        if (rd_en) begin
            case (io_addr)
                A_OUT:   rdata_d = zext(out_q);
                A_DIR:   rdata_d = zext(dir_q);
                A_IN:    rdata_d = zext(in_w);
                A_RISE:  rdata_d = zext(rise_q);
                A_FALL:  rdata_d = zext(fall_q);
                A_PEND:  rdata_d = zext(pend_q);
                default: rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q   <= OUT_RESET;
            dir_q   <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            pend_q  <= '0;
            prev_q  <= '0;
            sync_q  <= '0;
            rdata_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            sync_q[0] <= pin_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q  <= in_w;
            out_q   <= out_d;
            dir_q   <= dir_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            pend_q  <= pend_d;
            rdata_q <= rdata_d;
            irq_q   <= |(pend_q & (rise_q | fall_q));
        end
    end

    assign io_rdata = rdata_q;
    assign pin_out  = out_q;
    assign pin_oe   = dir_q;
    assign irq      = irq_q;

endmodule
